// File: rtl/qif_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qif_pkg
//  Purpose  : Shared defaults, FSM state type and saturation helper for the
//             QIF neuron datapath and its scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package qif_pkg;

    // Default datapath width and membrane constants
    localparam int QIF_DATA_W  = 8;
    localparam int QIF_V_RESET = -20;
    localparam int QIF_V_PEAK  = 50;

    // Working width of the saturation helper; any sum up to this width fits
    localparam int QIF_SAT_IN_W = 40;
    localparam logic signed [QIF_SAT_IN_W-1:0] QIF_SAT_ONE = {{(QIF_SAT_IN_W-1){1'b0}}, 1'b1};

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } qif_state_t;

    // Saturation decision for a w-bit signed target:
    // 2'b01 = above max (clip high), 2'b10 = below min (clip low), 2'b00 = in range.
    function automatic logic [1:0] qif_sat_dir(input logic signed [QIF_SAT_IN_W-1:0] x,
                                               input int w);
        logic signed [QIF_SAT_IN_W-1:0] hi;
        logic signed [QIF_SAT_IN_W-1:0] lo;
        hi = (QIF_SAT_ONE <<< (w - 1)) - QIF_SAT_ONE;
        lo = -hi - QIF_SAT_ONE;
        if (x > hi) begin
            return 2'b01;
        end
        if (x < lo) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qif_update_core.sv
`default_nettype none
// ============================================================================
//  Module   : qif_update_core
//  Purpose  : Combinational QIF step: v_next = sat(v + (b>>>2) + ((v*v)>>>4)),
//             fire when v >= V_PEAK. Shared by the scheduler and the
//             single-neuron wrapper.
//  Revision : 1.0 - initial release
// ============================================================================
module qif_update_core
    import qif_pkg::*;
#(
    parameter int DATA_W = QIF_DATA_W,
    parameter int V_PEAK = QIF_V_PEAK
) (
    input  logic signed [DATA_W-1:0] i_v,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_v_next,
    output logic                     o_fire
);

    localparam int SUM_W = 2 * DATA_W + 2;
    localparam logic signed [DATA_W-1:0] c_v_peak = V_PEAK[DATA_W-1:0];
    localparam logic signed [DATA_W-1:0] c_max    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_min    = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0]     w_v_wide;
    logic signed [2*DATA_W-1:0]     w_sq;
    logic signed [2*DATA_W-1:0]     w_sq_sh;
    logic signed [DATA_W-1:0]       w_b_sh;
    logic signed [SUM_W-1:0]        w_sum;
    logic signed [QIF_SAT_IN_W-1:0] w_sum_ext;
    logic [1:0]                     w_sat_dir;

    // Square is exact in 2*DATA_W bits; arithmetic shifts floor toward -inf
    assign w_v_wide  = {{DATA_W{i_v[DATA_W-1]}}, i_v};
    assign w_sq      = w_v_wide * w_v_wide;
    assign w_sq_sh   = w_sq >>> 4;
    assign w_b_sh    = i_b >>> 2;
    assign w_sum     = {{(SUM_W-DATA_W){i_v[DATA_W-1]}}, i_v}
                     + {{(SUM_W-DATA_W){w_b_sh[DATA_W-1]}}, w_b_sh}
                     + {{2{w_sq_sh[2*DATA_W-1]}}, w_sq_sh};
    assign w_sum_ext = {{(QIF_SAT_IN_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};
    assign w_sat_dir = qif_sat_dir(w_sum_ext, DATA_W);

    // Clip the wide sum into the signed DATA_W range; never wrap
    always_comb begin
        o_v_next = w_sum[DATA_W-1:0];
        case (w_sat_dir)
            2'b01:   o_v_next = c_max;
            2'b10:   o_v_next = c_min;
            default: o_v_next = w_sum[DATA_W-1:0];
        endcase
    end

    assign o_fire = (i_v >= c_v_peak);

endmodule
`default_nettype wire

// File: rtl/qif_neuron_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : qif_neuron_scheduler
//  Purpose  : Time-multiplexes one QIF update core over N_NEURONS neurons.
//             A tick sweeps all neurons in index order; firing neurons emit
//             one spike event each on a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module qif_neuron_scheduler
    import qif_pkg::*;
#(
    parameter  int N_NEURONS = 4,
    parameter  int DATA_W    = QIF_DATA_W,
    parameter  int V_RESET   = QIF_V_RESET,
    parameter  int V_PEAK    = QIF_V_PEAK,
    localparam int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data,
    input  logic [IDX_W-1:0]         mon_sel,
    output logic signed [DATA_W-1:0] v_mon,
    output logic                     busy,
    output logic                     sweep_done,
    output logic                     overrun,
    output logic                     spk_valid,
    output logic [IDX_W-1:0]         spk_id,
    input  logic                     spk_ready
);

    localparam logic signed [DATA_W-1:0] c_v_reset = V_RESET[DATA_W-1:0];
    localparam logic [IDX_W-1:0]         c_last    = IDX_W'(N_NEURONS - 1);

    qif_state_t               r_state;
    qif_state_t               w_state_next;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         w_idx_next;
    logic                     r_overrun;
    logic signed [DATA_W-1:0] r_v [N_NEURONS];
    logic signed [DATA_W-1:0] r_b [N_NEURONS];

    logic                     w_last;
    logic                     w_v_we;
    logic signed [DATA_W-1:0] w_v_wdata;
    logic signed [DATA_W-1:0] w_v_next;
    logic                     w_fire;

    // Shared datapath evaluates the neuron currently addressed by r_idx
    qif_update_core #(
        .DATA_W (DATA_W),
        .V_PEAK (V_PEAK)
    ) u_core (
        .i_v      (r_v[r_idx]),
        .i_b      (r_b[r_idx]),
        .o_v_next (w_v_next),
        .o_fire   (w_fire)
    );

    assign w_last = (r_idx == c_last);

    // State and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state, index advance and V write-back decisions
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_v_we       = 1'b0;
        w_v_wdata    = w_v_next;
        case (r_state)
            ST_IDLE: begin
                if (tick) begin
                    w_state_next = ST_UPDATE;
                    w_idx_next   = '0;
                end
            end
            ST_UPDATE: begin
                w_v_we = 1'b1;
                if (w_fire) begin
                    // Firing is decided on the stored V; the event goes out first
                    w_v_wdata    = c_v_reset;
                    w_state_next = ST_EMIT;
                end else if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end
            ST_EMIT: begin
                // Hold the event until the consumer takes it
                if (spk_ready) begin
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_idx_next   = r_idx + IDX_W'(1);
                        w_state_next = ST_UPDATE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    // Membrane bank: reset to V_RESET, written only by the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i] <= c_v_reset;
            end
        end else if (w_v_we) begin
            r_v[r_idx] <= w_v_wdata;
        end
    end

    // Input-current bank: host writes land next cycle; an update in flight reads the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_b[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_addr) < N_NEURONS)) begin
            r_b[cfg_addr] <= cfg_data;
        end
    end

    // Sticky overrun: any tick seen outside IDLE, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (tick && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign v_mon      = (int'(mon_sel) < N_NEURONS) ? r_v[mon_sel] : c_v_reset;
    assign busy       = (r_state != ST_IDLE);
    assign sweep_done = (r_state == ST_DONE);
    assign overrun    = r_overrun;
    assign spk_valid  = (r_state == ST_EMIT);
    assign spk_id     = (r_state == ST_EMIT) ? r_idx : '0;

endmodule
`default_nettype wire

// File: tb/tb_qif_neuron_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qif_neuron_scheduler
//  Purpose  : Directed self-checking bench for qif_neuron_scheduler with
//             hand-computed membrane trajectories (N=4, DATA_W=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qif_neuron_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 tick;
    logic                 cfg_we;
    logic [1:0]           cfg_addr;
    logic [DW-1:0]        cfg_data;
    logic [1:0]           mon_sel;
    logic signed [DW-1:0] v_mon;
    logic                 busy;
    logic                 sweep_done;
    logic                 overrun;
    logic                 spk_valid;
    logic [1:0]           spk_id;
    logic                 spk_ready;

    int n_checks;
    int n_errors;
    int spk_q[$];

    qif_neuron_scheduler #(
        .N_NEURONS (N),
        .DATA_W    (DW),
        .V_RESET   (-20),
        .V_PEAK    (50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .mon_sel    (mon_sel),
        .v_mon      (v_mon),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overrun    (overrun),
        .spk_valid  (spk_valid),
        .spk_id     (spk_id),
        .spk_ready  (spk_ready)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Record every accepted spike event
    always @(posedge clk) begin
        if (rst_n && spk_valid && spk_ready) begin
            spk_q.push_back(int'(spk_id));
        end
    end

    // Hard stop if something hangs
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(act), $signed(exp));
        end
    endtask

    task automatic check_v(input int idx, input int exp, input string tag);
        mon_sel = idx[1:0];
        #1;
        chk($sformatf("%s_v%0d", tag, idx), int'(v_mon), exp);
    endtask

    task automatic check_vs(input int e0, input int e1, input int e2, input int e3,
                            input string tag);
        check_v(0, e0, tag);
        check_v(1, e1, tag);
        check_v(2, e2, tag);
        check_v(3, e3, tag);
    endtask

    task automatic write_b(input int a, input int d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = a[1:0];
        cfg_data = d[7:0];
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Pulse tick, count edges from the sampling edge until sweep_done is seen
    task automatic run_sweep(input int exp_cyc, input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (sweep_done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk({tag, "_latency"}, cyc, exp_cyc);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic start_tick();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int cyc;
        cyc = 0;
        while (!spk_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_valid_seen"}, spk_valid, 1'b1);
    endtask

    initial begin
        int cyc;
        int ndone;
        clk       = 1'b0;
        rst_n     = 1'b0;
        tick      = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        mon_sel   = '0;
        spk_ready = 1'b1;
        n_checks  = 0;
        n_errors  = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_vs(-20, -20, -20, -20, "rst");
        chk("rst_busy", busy, 1'b0);
        chk("rst_spk_valid", spk_valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_sweep_done", sweep_done, 1'b0);
        chk("rst_spk_id", spk_id, 2'd0);

        // B = {100, 127, 0, -3}; -3>>>2 = -1 keeps neuron 3 pinned at 4
        write_b(0, 100);
        write_b(1, 127);
        write_b(2, 0);
        write_b(3, -3);

        run_sweep(N + 1, "sw1");
        check_vs(30, 36, 5, 4, "sw1");
        run_sweep(N + 1, "sw2");
        check_vs(111, 127, 6, 4, "sw2");       // 148 saturates to 127
        run_sweep(N + 3, "sw3");               // two spikes, ready high
        check_vs(-20, -20, 8, 4, "sw3");
        chk("sw3_spk_count", spk_q.size(), 2);
        chk("sw3_spk0_id", spk_q[0], 0);
        chk("sw3_spk1_id", spk_q[1], 1);

        // Arrange neurons 0 and 2 to fire together
        write_b(1, 0);
        write_b(2, 127);
        run_sweep(N + 1, "sw4");
        check_vs(30, 5, 43, 4, "sw4");
        run_sweep(N + 1, "sw5");
        check_vs(111, 6, 127, 4, "sw5");

        // Backpressure: event for neuron 0 must stay put for 5 stalled cycles
        spk_ready = 1'b0;
        start_tick();
        wait_valid("sw6");
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", spk_valid, 1'b1);
            chk("stall_id", spk_id, 2'd0);
            chk("stall_busy", busy, 1'b1);
            chk("stall_done", sweep_done, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("stall_no_accept", spk_q.size(), 2);
        spk_ready = 1'b1;
        cyc = 0;
        while (!sweep_done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("sw6_done_seen", sweep_done, 1'b1);
        chk("sw6_spk_count", spk_q.size(), 4);
        chk("sw6_spk2_id", spk_q[2], 0);
        chk("sw6_spk3_id", spk_q[3], 2);
        @(posedge clk);
        #1;
        check_vs(-20, 8, -20, 4, "sw6");

        // Tick while busy: flagged, but no second sweep
        start_tick();
        chk("ovr_before", overrun, 1'b0);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        chk("ovr_set", overrun, 1'b1);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (sweep_done) ndone++;
            @(posedge clk);
            #1;
        end
        chk("ovr_one_sweep", ndone, 1);
        chk("ovr_idle", busy, 1'b0);
        check_vs(30, 12, 36, 4, "sw7");
        run_sweep(N + 1, "sw8");
        check_vs(111, 21, 127, 4, "sw8");
        chk("ovr_sticky", overrun, 1'b1);

        // Reset asserted while an event is pending
        spk_ready = 1'b0;
        start_tick();
        wait_valid("sw9");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_spk_valid", spk_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_overrun", overrun, 1'b0);
        check_vs(-20, -20, -20, -20, "mid_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        spk_ready = 1'b1;
        run_sweep(N + 1, "post_rst");
        check_vs(5, 5, 5, 5, "post_rst");      // B cleared by reset
        chk("post_rst_spk_count", spk_q.size(), 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
